// File: rtl/de2_pio_pkg.sv
// rtl/de2_pio_pkg.sv - shared register map, status bits and pulse states for the LED PIO
package de2_pio_pkg;

    localparam logic [2:0] ADDR_DATA       = 3'd0;
    localparam logic [2:0] ADDR_OUTSET     = 3'd1;
    localparam logic [2:0] ADDR_OUTCLEAR   = 3'd2;
    localparam logic [2:0] ADDR_BLINK_MASK = 3'd3;
    localparam logic [2:0] ADDR_BLINK_PER  = 3'd4;
    localparam logic [2:0] ADDR_PULSE_LEN  = 3'd5;
    localparam logic [2:0] ADDR_PULSE      = 3'd6;
    localparam logic [2:0] ADDR_STATUS     = 3'd7;

    localparam int STATUS_DONE   = 0;
    localparam int STATUS_IRQ_EN = 1;
    localparam int STATUS_BUSY   = 2;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } pulse_state_t;

endpackage

// File: rtl/de2_pio_leds_out_if.sv
// rtl/de2_pio_leds_out_if.sv - Avalon-MM slave bus bundle for the LED PIO
interface de2_pio_leds_out_if;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (output address, chipselect, write_n, writedata, input readdata);
    modport slave  (input address, chipselect, write_n, writedata, output readdata);
endinterface

// File: rtl/de2_pio_tick_gen.sv
// rtl/de2_pio_tick_gen.sv - reload down-counter emitting one tick every period cycles
module de2_pio_tick_gen #(
    parameter int CNT_W = 26
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [CNT_W-1:0] i_period,
    input  logic             i_restart,
    output logic             o_tick
);
    localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [CNT_W-1:0] r_cnt;
    logic             w_active;

    // A zero period parks the counter; a restart suppresses any tick in the same cycle
    assign w_active = |i_period;
    assign o_tick   = w_active && !i_restart && (r_cnt == '0);

    // Count down to zero, then reload period-1; restart reloads immediately
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (!w_active) begin
            r_cnt <= '0;
        end else if (i_restart || (r_cnt == '0)) begin
            r_cnt <= i_period - ONE;
        end else begin
            r_cnt <= r_cnt - ONE;
        end
    end
endmodule

// File: rtl/de2_pio_leds_out.sv
// rtl/de2_pio_leds_out.sv - LED output PIO with set/clear latch, blink generator and pulse timer
module de2_pio_leds_out
    import de2_pio_pkg::*;
#(
    parameter int          WIDTH       = 8,
    parameter int          CNT_W       = 26,
    parameter logic [31:0] RESET_VALUE = 32'h0
) (
    input  logic                clk,
    input  logic                reset,
    de2_pio_leds_out_if.slave   bus,
    output logic                irq,
    output logic [WIDTH-1:0]    out_port
);
    localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] r_data, r_blink_mask, r_pulse_mask, r_out;
    logic [CNT_W-1:0] r_blink_per, r_pulse_len, r_pulse_cnt;
    logic             r_phase, r_done, r_irq_en;
    logic [31:0]      r_readdata;
    pulse_state_t     r_state, w_state_nxt;

    logic             w_wr;
    logic [WIDTH-1:0] w_wd;
    logic [CNT_W-1:0] w_wd_cnt, w_blink_per_nxt;
    logic             w_wr_bper, w_wr_pulse, w_wr_status;
    logic             w_pulse_go, w_pulse_kill, w_cnt_zero;
    logic             w_load, w_clear, w_expire, w_tick;
    logic             w_unused_wd;

    assign w_wr        = bus.chipselect && !bus.write_n;
    assign w_wd        = bus.writedata[WIDTH-1:0];
    assign w_wd_cnt    = bus.writedata[CNT_W-1:0];
    assign w_unused_wd = ^bus.writedata;
    assign w_wr_bper   = w_wr && (bus.address == ADDR_BLINK_PER);
    assign w_wr_pulse  = w_wr && (bus.address == ADDR_PULSE);
    assign w_wr_status = w_wr && (bus.address == ADDR_STATUS);

    // A pulse write starts/restarts only with a non-empty mask and a non-zero length
    assign w_pulse_go   = w_wr_pulse && (|w_wd) && (|r_pulse_len);
    assign w_pulse_kill = w_wr_pulse && !w_pulse_go;
    assign w_cnt_zero   = (r_pulse_cnt == '0);

    // DATA latch with direct write, atomic set and atomic clear
    always_ff @(posedge clk) begin
        if (reset) begin
            r_data <= RESET_VALUE[WIDTH-1:0];
        end else if (w_wr && bus.address == ADDR_DATA) begin
            r_data <= w_wd;
        end else if (w_wr && bus.address == ADDR_OUTSET) begin
            r_data <= r_data | w_wd;
        end else if (w_wr && bus.address == ADDR_OUTCLEAR) begin
            r_data <= r_data & ~w_wd;
        end
    end

    // Plain configuration registers
    always_ff @(posedge clk) begin
        if (reset) begin
            r_blink_mask <= '0;
            r_blink_per  <= '0;
            r_pulse_len  <= '0;
            r_irq_en     <= 1'b0;
        end else if (w_wr) begin
            if (bus.address == ADDR_BLINK_MASK) r_blink_mask <= w_wd;
            if (bus.address == ADDR_BLINK_PER)  r_blink_per  <= w_wd_cnt;
            if (bus.address == ADDR_PULSE_LEN)  r_pulse_len  <= w_wd_cnt;
            if (bus.address == ADDR_STATUS)     r_irq_en     <= bus.writedata[STATUS_IRQ_EN];
        end
    end

    // The tick counter sees the period being written so the reload uses the new value
    assign w_blink_per_nxt = w_wr_bper ? w_wd_cnt : r_blink_per;

    de2_pio_tick_gen #(.CNT_W(CNT_W)) u_blink_tick (
        .clk       (clk),
        .reset     (reset),
        .i_period  (w_blink_per_nxt),
        .i_restart (w_wr_bper),
        .o_tick    (w_tick)
    );

    // Blink phase: cleared by a period write or zero period, toggled on each tick
    always_ff @(posedge clk) begin
        if (reset || w_wr_bper || (r_blink_per == '0)) begin
            r_phase <= 1'b0;
        end else if (w_tick) begin
            r_phase <= ~r_phase;
        end
    end

    // Pulse FSM state register
    always_ff @(posedge clk) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_state_nxt;
    end

    // Pulse FSM next state: pulse writes take priority over natural expiry
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: if (w_pulse_go) w_state_nxt = RUN;
            RUN: begin
                if (w_pulse_go)        w_state_nxt = RUN;
                else if (w_pulse_kill) w_state_nxt = IDLE;
                else if (w_cnt_zero)   w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Pulse FSM outputs: load mask/count, clear on abort or expiry, flag expiry
    always_comb begin
        w_load   = w_pulse_go;
        w_clear  = 1'b0;
        w_expire = 1'b0;
        if (r_state == RUN) begin
            w_expire = !w_wr_pulse && w_cnt_zero;
            w_clear  = w_pulse_kill || w_expire;
        end
    end

    // Pulse mask and length counter
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pulse_mask <= '0;
            r_pulse_cnt  <= '0;
        end else if (w_load) begin
            r_pulse_mask <= w_wd;
            r_pulse_cnt  <= r_pulse_len - ONE;
        end else if (w_clear) begin
            r_pulse_mask <= '0;
            r_pulse_cnt  <= '0;
        end else if (r_state == RUN) begin
            r_pulse_cnt  <= r_pulse_cnt - ONE;
        end
    end

    // Sticky done: expiry sets it and wins over a coincident clear
    always_ff @(posedge clk) begin
        if (reset) begin
            r_done <= 1'b0;
        end else if (w_expire) begin
            r_done <= 1'b1;
        end else if (w_wr_status && bus.writedata[STATUS_DONE]) begin
            r_done <= 1'b0;
        end
    end

    assign irq = r_done && r_irq_en;

    // Registered LED drive combining latch, blink and pulse overlay
    always_ff @(posedge clk) begin
        if (reset) r_out <= RESET_VALUE[WIDTH-1:0];
        else       r_out <= (r_data ^ (r_blink_mask & {WIDTH{r_phase}})) | r_pulse_mask;
    end

    assign out_port = r_out;

    // Read mux registered every cycle from address alone
    always_ff @(posedge clk) begin
        if (reset) begin
            r_readdata <= '0;
        end else begin
            case (bus.address)
                ADDR_DATA, ADDR_OUTSET, ADDR_OUTCLEAR: r_readdata <= 32'(r_data);
                ADDR_BLINK_MASK: r_readdata <= 32'(r_blink_mask);
                ADDR_BLINK_PER:  r_readdata <= 32'(r_blink_per);
                ADDR_PULSE_LEN:  r_readdata <= 32'(r_pulse_len);
                ADDR_PULSE:      r_readdata <= 32'(r_pulse_mask);
                ADDR_STATUS:     r_readdata <= {29'd0, (r_state == RUN), r_irq_en, r_done};
                default:         r_readdata <= '0;
            endcase
        end
    end

    assign bus.readdata = r_readdata;
endmodule

// File: tb/tb_de2_pio_leds_out.sv
// tb/tb_de2_pio_leds_out.sv - self-checking bench for the LED output PIO
module tb_de2_pio_leds_out;
    logic       clk = 1'b0;
    logic       reset;
    logic       irq;
    logic [7:0] out_port;
    int         n_tests = 0;
    int         n_fail  = 0;

    de2_pio_leds_out_if bus ();

    de2_pio_leds_out #(.WIDTH(8), .CNT_W(26), .RESET_VALUE(32'h5A)) dut (
        .clk      (clk),
        .reset    (reset),
        .bus      (bus),
        .irq      (irq),
        .out_port (out_port)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  waddr;
        logic [31:0] wdata;
        logic [2:0]  raddr;
        logic [31:0] exp_rd;
        logic [7:0]  exp_out;
    } vec_t;

    vec_t vecs[11];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // All bus tasks start and end just after a falling edge
    task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
        bus.address    = a;
        bus.writedata  = d;
        bus.chipselect = 1'b1;
        bus.write_n    = 1'b0;
        @(negedge clk);
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
    endtask

    task automatic bus_read(input logic [2:0] a, output logic [31:0] d);
        bus.address = a;
        @(negedge clk);
        d = bus.readdata;
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        logic [31:0] rd;

        vecs[0]  = '{3'd0, 32'h0000_000F, 3'd0, 32'h0F, 8'h0F};
        vecs[1]  = '{3'd1, 32'h0000_00C0, 3'd1, 32'hCF, 8'hCF};
        vecs[2]  = '{3'd2, 32'h0000_0003, 3'd1, 32'hCC, 8'hCC};
        vecs[3]  = '{3'd2, 32'hFFFF_FF00, 3'd2, 32'hCC, 8'hCC};
        vecs[4]  = '{3'd3, 32'h0000_0000, 3'd3, 32'h00, 8'hCC};
        vecs[5]  = '{3'd5, 32'h0000_000A, 3'd5, 32'h0A, 8'hCC};
        vecs[6]  = '{3'd4, 32'h0000_0000, 3'd4, 32'h00, 8'hCC};
        vecs[7]  = '{3'd0, 32'h0000_01FF, 3'd0, 32'hFF, 8'hFF};
        vecs[8]  = '{3'd7, 32'h0000_0002, 3'd7, 32'h02, 8'hFF};
        vecs[9]  = '{3'd6, 32'h0000_0000, 3'd6, 32'h00, 8'hFF};
        vecs[10] = '{3'd2, 32'h0000_00FF, 3'd0, 32'h00, 8'h00};

        bus.address    = 3'd0;
        bus.writedata  = 32'd0;
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
        reset          = 1'b1;
        tick(3);
        check("rst_out", 32'(out_port), 32'h5A);
        check("rst_readdata", bus.readdata, 32'h0);
        check("rst_irq", 32'(irq), 32'h0);
        reset = 1'b0;
        for (int a = 0; a < 8; a++) begin
            bus_read(3'(a), rd);
            check($sformatf("rst_reg%0d", a), rd, (a <= 2) ? 32'h5A : 32'h0);
        end

        // Register access vectors
        for (int i = 0; i < 11; i++) begin
            bus_write(vecs[i].waddr, vecs[i].wdata);
            bus_read(vecs[i].raddr, rd);
            check($sformatf("vec%0d_rd", i), rd, vecs[i].exp_rd);
            check($sformatf("vec%0d_out", i), 32'(out_port), 32'(vecs[i].exp_out));
        end

        // Blink: half-period 4 on bit 0
        bus_write(3'd3, 32'h01);
        bus_write(3'd4, 32'd4);
        for (int k = 1; k <= 16; k++) begin
            tick(1);
            check($sformatf("blink_k%0d", k), 32'(out_port), (((k - 1) / 4) % 2 == 1) ? 32'h01 : 32'h00);
        end
        bus_write(3'd4, 32'd0);
        tick(2);
        check("blink_off", 32'(out_port), 32'h0);
        tick(5);
        check("blink_off_hold", 32'(out_port), 32'h0);
        bus_write(3'd3, 32'h0);

        // Single pulse of 10 cycles with irq enabled
        bus_write(3'd6, 32'h80);
        for (int k = 1; k <= 12; k++) begin
            tick(1);
            check($sformatf("pulse_out_k%0d", k), 32'(out_port), (k <= 10) ? 32'h80 : 32'h00);
            check($sformatf("pulse_irq_k%0d", k), 32'(irq), (k >= 10) ? 32'h1 : 32'h0);
        end
        bus_read(3'd7, rd);
        check("pulse_status_done", rd, 32'h3);
        bus_write(3'd7, 32'h3);
        check("pulse_irq_cleared", 32'(irq), 32'h0);
        bus_read(3'd7, rd);
        check("pulse_status_clr", rd, 32'h2);

        // Restart at cycle 5 with a new mask
        bus_write(3'd6, 32'h80);
        tick(4);
        bus_write(3'd6, 32'h40);
        for (int k = 6; k <= 17; k++) begin
            tick(1);
            check($sformatf("restart_out_k%0d", k), 32'(out_port), (k <= 15) ? 32'h40 : 32'h00);
            check($sformatf("restart_irq_k%0d", k), 32'(irq), (k >= 15) ? 32'h1 : 32'h0);
        end
        bus_write(3'd7, 32'h3);

        // Restart on the very expiry edge: no done from the first pulse
        bus_write(3'd6, 32'h80);
        tick(9);
        bus_write(3'd6, 32'h40);
        check("coinc_no_done", 32'(irq), 32'h0);
        bus_read(3'd6, rd);
        check("coinc_mask", rd, 32'h40);
        tick(9);
        check("coinc_done_later", 32'(irq), 32'h1);
        bus_write(3'd7, 32'h3);

        // Abort with a zero-mask write
        bus_write(3'd6, 32'h20);
        bus_read(3'd6, rd);
        check("abort_mask_run", rd, 32'h20);
        tick(2);
        bus_write(3'd6, 32'h0);
        tick(15);
        check("abort_irq", 32'(irq), 32'h0);
        check("abort_out", 32'(out_port), 32'h0);
        bus_read(3'd7, rd);
        check("abort_status", rd, 32'h2);
        bus_read(3'd6, rd);
        check("abort_mask_idle", rd, 32'h0);

        // Reset mid-pulse with blink running
        bus_write(3'd0, 32'h0F);
        bus_write(3'd3, 32'h01);
        bus_write(3'd4, 32'd3);
        bus_write(3'd6, 32'h80);
        tick(2);
        reset = 1'b1;
        tick(1);
        check("midrst_out", 32'(out_port), 32'h5A);
        check("midrst_irq", 32'(irq), 32'h0);
        check("midrst_readdata", bus.readdata, 32'h0);
        reset = 1'b0;
        tick(12);
        check("postrst_out", 32'(out_port), 32'h5A);
        check("postrst_irq", 32'(irq), 32'h0);
        for (int a = 3; a < 8; a++) begin
            bus_read(3'(a), rd);
            check($sformatf("postrst_reg%0d", a), rd, 32'h0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
